// File: rtl/pwm_cfg_spi_master.sv
// Round-robin arbitrated SPI master that ships {duty, div} frames LSB first to a PWM slave.
// Define PWM_CFG_LOOPBACK_CHECK_EN to add the spi_miso loopback compare and sticky loopback_err.
module pwm_cfg_spi_master #(
  parameter int NUM_REQ          = 2,
  parameter int CLOCK_DIV_WIDTH  = 32,
  parameter int DUTY_CYCLE_WIDTH = 8,
  parameter int SCLK_HALF        = 4,
  parameter int CS_GAP           = 2,
  localparam int GIDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*CLOCK_DIV_WIDTH-1:0]    req_div,
  input  logic [NUM_REQ*DUTY_CYCLE_WIDTH-1:0]   req_duty,
  output logic [GIDW-1:0]                       grant_id,
  output logic                                  busy,
  output logic                                  done,
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
  input  logic                                  spi_miso,
  output logic                                  loopback_err,
`endif
  output logic                                  spi_sclk,
  output logic                                  spi_mosi,
  output logic                                  spi_cs
);
  localparam int N    = CLOCK_DIV_WIDTH + DUTY_CYCLE_WIDTH;
  localparam int HMAX = (SCLK_HALF > CS_GAP) ? SCLK_HALF : CS_GAP;
  localparam int HW   = $clog2(HMAX) + 1;
  localparam int BW   = $clog2(N) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [HW-1:0]           cnt_r, cnt_nxt_s;
  logic [BW-1:0]           bit_r, bit_nxt_s;
  logic [N-1:0]            frame_r, frame_nxt_s;
  logic [GIDW-1:0]         grant_r, grant_nxt_s, ptr_r, ptr_nxt_s, win_s;
  logic [GIDW:0]           idx_s;
  logic                    found_s, accept_s, half_end_s, gap_end_s;
  logic                    cs_r, cs_nxt_s, sclk_r, sclk_nxt_s;
  logic                    busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic [CLOCK_DIV_WIDTH-1:0]  sel_div_s;
  logic [DUTY_CYCLE_WIDTH-1:0] sel_duty_s;
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
  logic                    err_r, err_nxt_s;
`endif

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = {1'b0, ptr_r} + (GIDW+1)'(i);
      if (idx_s >= (GIDW+1)'(NUM_REQ)) begin
        idx_s = idx_s - (GIDW+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_valid[idx_s[GIDW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[GIDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign accept_s   = (state_r == ST_IDLE) && found_s;
  assign sel_div_s  = req_div[win_s*CLOCK_DIV_WIDTH +: CLOCK_DIV_WIDTH];
  assign sel_duty_s = req_duty[win_s*DUTY_CYCLE_WIDTH +: DUTY_CYCLE_WIDTH];
  assign half_end_s = (cnt_r == HW'(SCLK_HALF-1));
  assign gap_end_s  = (cnt_r == HW'(CS_GAP-1));

  // Ready is offered only to the current winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst && accept_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state, counters and shift data; pin levels follow the next state so they are registered.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    frame_nxt_s = frame_r;
    grant_nxt_s = grant_r;
    ptr_nxt_s   = ptr_r;
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
    err_nxt_s   = err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SETUP;
          cnt_nxt_s   = '0;
          bit_nxt_s   = '0;
          frame_nxt_s = {sel_duty_s, sel_div_s};
          grant_nxt_s = win_s;
          ptr_nxt_s   = (win_s == GIDW'(NUM_REQ-1)) ? '0 : win_s + GIDW'(1);
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
          err_nxt_s   = 1'b0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (half_end_s) begin
          state_nxt_s = ST_HIGH;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + HW'(1);
        end
      end
      ST_HIGH: begin
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
        if (half_end_s && (spi_miso != frame_r[0])) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
`endif
        if (half_end_s) begin
          cnt_nxt_s = '0;
          bit_nxt_s = bit_r + BW'(1);
          if (bit_r == BW'(N-1)) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_LOW;
            frame_nxt_s = {1'b0, frame_r[N-1:1]};
          end
        end else begin
          cnt_nxt_s = cnt_r + HW'(1);
        end
      end
      ST_HOLD: begin
        if (half_end_s) begin
          state_nxt_s = ST_GAP;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + HW'(1);
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          frame_nxt_s = '0;
        end else begin
          cnt_nxt_s   = cnt_r + HW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
    sclk_nxt_s = (state_nxt_s == ST_HIGH);
    cs_nxt_s   = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_GAP);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_GAP) && (cnt_nxt_s == HW'(CS_GAP-1));
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      bit_r   <= '0;
      frame_r <= '0;
      grant_r <= '0;
      ptr_r   <= '0;
      cs_r    <= 1'b1;
      sclk_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      frame_r <= frame_nxt_s;
      grant_r <= grant_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cs_r    <= cs_nxt_s;
      sclk_r  <= sclk_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
      err_r   <= err_nxt_s;
`endif
    end
  end

  assign grant_id = grant_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign spi_sclk = sclk_r;
  assign spi_mosi = frame_r[0];
  assign spi_cs   = cs_r;
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
  assign loopback_err = err_r;
`endif
endmodule

// File: tb/tb_pwm_cfg_spi_master.sv
// Self-checking bench for pwm_cfg_spi_master: pin-level frame capture against a round-robin/frame model.
// Loopback scenario is built only when PWM_CFG_LOOPBACK_CHECK_EN is defined.
module tb_pwm_cfg_spi_master;
  localparam int NUM_REQ = 2;
  localparam int CDW = 32;
  localparam int DDW = 8;
  localparam int H = 4;
  localparam int G = 2;
  localparam int N = CDW + DDW;
  localparam int LAT = H * (2 * N + 1) + G;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*CDW-1:0] req_div = '0;
  logic [NUM_REQ*DDW-1:0] req_duty = '0;
  logic [0:0] grant_id;
  logic busy, done, spi_sclk, spi_mosi, spi_cs;
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
  logic inv_r = 1'b0;
  logic spi_miso, loopback_err;
  assign spi_miso = spi_mosi ^ inv_r;
`endif

  pwm_cfg_spi_master #(.NUM_REQ(NUM_REQ), .CLOCK_DIV_WIDTH(CDW), .DUTY_CYCLE_WIDTH(DDW),
                       .SCLK_HALF(H), .CS_GAP(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_div(req_div), .req_duty(req_duty), .grant_id(grant_id),
    .busy(busy), .done(done),
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
    .spi_miso(spi_miso), .loopback_err(loopback_err),
`endif
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs(spi_cs));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [CDW-1:0] div_v [NUM_REQ];
  logic [DDW-1:0] duty_v [NUM_REQ];
  int rr_m = 0;

  int n_rise, lat, done_cnt, done_at, bad_edge, mosi_unstable;
  int hi_min, hi_max, lo_min, lo_max, lead, tail, gap;
  int ready_busy, ready_multi, obs_win, to_flag;
  logic rs_cs, rs_sclk, rs_busy, rs_done;
  logic [N-1:0] cap;

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_div[i*CDW +: CDW] = div_v[i];
      req_duty[i*DDW +: DDW] = duty_v[i];
    end
  endtask

  // Reference arbiter: first valid index at or after the model pointer, wrapping.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
    int j;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (rr_m + i) % NUM_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_frame(input int w);
    return {duty_v[w], div_v[w]};
  endfunction

  // Waits for a transfer, then records pin activity until busy drops (called at a negedge).
  task automatic run_frame(input int mode);
    logic prev_sclk, prev_mosi;
    int hi_run, lo_run;
    bit fin;
    n_rise = 0; lat = 0; done_cnt = 0; done_at = -1; bad_edge = 0; mosi_unstable = 0;
    hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0; lead = -1; tail = 0; gap = 0;
    ready_busy = 0; obs_win = -1; to_flag = 0; cap = '0;
    prev_sclk = 1'b0; prev_mosi = 1'b0; hi_run = 0; lo_run = 0; fin = 1'b0;
    for (int c = 0; c < 200 && obs_win < 0; c++) begin
      #1;
      if ($countones(req_ready) > 1) ready_multi++;
      for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) obs_win = i;
      if (obs_win < 0) @(negedge clk);
    end
    if (obs_win < 0) begin
      to_flag = 1;
      return;
    end
    for (int c = 0; c < 1000 && !fin; c++) begin
      @(negedge clk);
      if (!busy) begin
        if (done) done_cnt++;
        fin = 1'b1;
      end else begin
        lat++;
        if (req_ready != '0) ready_busy++;
        if (done) begin done_cnt++; done_at = lat; end
        if (spi_cs) gap++;
        if (spi_cs && spi_sclk) bad_edge++;
        if (spi_sclk && !prev_sclk) begin
          if (n_rise < N) cap[n_rise] = spi_mosi;
          if (spi_mosi !== prev_mosi) mosi_unstable++;
          if (n_rise == 0) lead = lo_run;
          else begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
          end
          n_rise++;
          hi_run = 0;
        end
        if (spi_sclk) hi_run++;
        if (!spi_sclk && prev_sclk) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          lo_run = 0;
        end
        if (!spi_sclk && !spi_cs) begin
          lo_run++;
          if (n_rise == N) tail++;
        end
        prev_sclk = spi_sclk;
        prev_mosi = spi_mosi;
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
        inv_r = (mode == 3) && (n_rise == 8);
`endif
        if (mode == 1 && lat == 50) begin
          req_valid = '1;
          div_v[0] = $urandom;
          drive_data();
        end
        if (mode == 2 && n_rise == 21) begin
          rst = 1'b0;
          req_valid = '0;
          @(negedge clk);
          rs_cs = spi_cs; rs_sclk = spi_sclk; rs_busy = busy; rs_done = done;
          if (done) done_cnt++;
          rst = 1'b1;
          fin = 1'b1;
        end
      end
    end
    if (!fin) to_flag = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (spi_cs !== 1'b1) $display("FAIL reset_cs got %b exp 1", spi_cs); else n_pass++;
    n_chk++; if (spi_sclk !== 1'b0) $display("FAIL reset_sclk got %b exp 0", spi_sclk); else n_pass++;
    n_chk++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b exp 0", spi_mosi); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_chk++; if (grant_id !== 1'b0) $display("FAIL reset_grant got %0d exp 0", grant_id); else n_pass++;
    req_valid = '1;
    #1;
    n_chk++; if (req_ready !== '0) $display("FAIL reset_ready got %b exp 0", req_ready); else n_pass++;
    req_valid = '0;
    rst = 1'b1;
    rr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0] exp_f;
    exp_f = 40'h80_0000_0005;
    div_v[0] = 32'h0000_0005; duty_v[0] = 8'h80;
    div_v[1] = 32'h1234_5678; duty_v[1] = 8'h5A;
    drive_data();
    req_valid = 2'b01;
    run_frame(0);
    req_valid = '0;
    rr_m = 1;
    n_chk++; if (to_flag !== 0) $display("FAIL single_timeout got %0d exp 0", to_flag); else n_pass++;
    n_chk++; if (obs_win !== 0) $display("FAIL single_win got %0d exp 0", obs_win); else n_pass++;
    n_chk++; if (n_rise !== N) $display("FAIL single_rises got %0d exp %0d", n_rise, N); else n_pass++;
    n_chk++; if (cap !== exp_f) $display("FAIL single_data got %h exp %h", cap, exp_f); else n_pass++;
    n_chk++; if (done_cnt !== 1) $display("FAIL single_done_cnt got %0d exp 1", done_cnt); else n_pass++;
    n_chk++; if (done_at !== LAT) $display("FAIL single_done_at got %0d exp %0d", done_at, LAT); else n_pass++;
    n_chk++; if (lat !== LAT) $display("FAIL single_latency got %0d exp %0d", lat, LAT); else n_pass++;
    n_chk++; if (bad_edge !== 0) $display("FAIL single_cs_edge got %0d exp 0", bad_edge); else n_pass++;
    n_chk++; if (ready_busy !== 0) $display("FAIL single_ready_busy got %0d exp 0", ready_busy); else n_pass++;
  endtask

  task automatic test_timing();
    div_v[1] = $urandom; duty_v[1] = 8'($urandom_range(0, 255));
    drive_data();
    req_valid = 2'b10;
    run_frame(0);
    req_valid = '0;
    rr_m = 0;
    n_chk++; if (to_flag !== 0) $display("FAIL timing_timeout got %0d exp 0", to_flag); else n_pass++;
    n_chk++; if (hi_min !== H || hi_max !== H) $display("FAIL timing_high got %0d..%0d exp %0d", hi_min, hi_max, H); else n_pass++;
    n_chk++; if (lo_min !== H || lo_max !== H) $display("FAIL timing_low got %0d..%0d exp %0d", lo_min, lo_max, H); else n_pass++;
    n_chk++; if (lead !== H) $display("FAIL timing_lead got %0d exp %0d", lead, H); else n_pass++;
    n_chk++; if (tail !== H) $display("FAIL timing_tail got %0d exp %0d", tail, H); else n_pass++;
    n_chk++; if (gap !== G) $display("FAIL timing_gap got %0d exp %0d", gap, G); else n_pass++;
    n_chk++; if (mosi_unstable !== 0) $display("FAIL timing_mosi_stable got %0d exp 0", mosi_unstable); else n_pass++;
    n_chk++; if (cap !== model_frame(1)) $display("FAIL timing_data got %h exp %h", cap, model_frame(1)); else n_pass++;
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] v;
    int e;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        div_v[i] = $urandom;
        duty_v[i] = 8'($urandom_range(0, 255));
      end
      drive_data();
      v = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      req_valid = v;
      e = model_pick(v);
      run_frame(0);
      req_valid = '0;
      rr_m = (e + 1) % NUM_REQ;
      n_chk++; if (obs_win !== e) $display("FAIL random_win[%0d] got %0d exp %0d", k, obs_win, e); else n_pass++;
      n_chk++; if (int'(grant_id) !== e) $display("FAIL random_grant[%0d] got %0d exp %0d", k, grant_id, e); else n_pass++;
      n_chk++; if (cap !== model_frame(e)) $display("FAIL random_data[%0d] got %h exp %h", k, cap, model_frame(e)); else n_pass++;
      n_chk++; if (done_cnt !== 1 || to_flag !== 0) $display("FAIL random_done[%0d] got %0d exp 1", k, done_cnt); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int e;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rr_m = 0;
    ready_multi = 0;
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      e = model_pick(req_valid);
      run_frame(0);
      rr_m = (e + 1) % NUM_REQ;
      n_chk++; if (obs_win !== (k % 2)) $display("FAIL b2b_win[%0d] got %0d exp %0d", k, obs_win, k % 2); else n_pass++;
      n_chk++; if (int'(grant_id) !== e) $display("FAIL b2b_grant[%0d] got %0d exp %0d", k, grant_id, e); else n_pass++;
      n_chk++; if (cap !== model_frame(e)) $display("FAIL b2b_data[%0d] got %h exp %h", k, cap, model_frame(e)); else n_pass++;
    end
    req_valid = '0;
    n_chk++; if (ready_multi !== 0) $display("FAIL b2b_ready_onehot got %0d exp 0", ready_multi); else n_pass++;
  endtask

  task automatic test_midframe_change();
    logic [N-1:0] exp_f;
    div_v[0] = $urandom; duty_v[0] = 8'($urandom_range(0, 255));
    drive_data();
    exp_f = model_frame(0);
    req_valid = 2'b01;
    run_frame(1);
    rr_m = 1;
    n_chk++; if (cap !== exp_f) $display("FAIL mid_data got %h exp %h", cap, exp_f); else n_pass++;
    n_chk++; if (ready_busy !== 0) $display("FAIL mid_ready_busy got %0d exp 0", ready_busy); else n_pass++;
    run_frame(0);
    req_valid = '0;
    rr_m = 0;
    n_chk++; if (obs_win !== 1) $display("FAIL mid_next_win got %0d exp 1", obs_win); else n_pass++;
    n_chk++; if (cap !== model_frame(1)) $display("FAIL mid_next_data got %h exp %h", cap, model_frame(1)); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    div_v[0] = $urandom; div_v[1] = $urandom;
    drive_data();
    req_valid = 2'b01;
    run_frame(2);
    rr_m = 0;
    n_chk++; if (rs_cs !== 1'b1 || rs_sclk !== 1'b0) $display("FAIL rstmid_pins got cs=%b sclk=%b exp cs=1 sclk=0", rs_cs, rs_sclk); else n_pass++;
    n_chk++; if (rs_busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", rs_busy); else n_pass++;
    n_chk++; if (done_cnt !== 0) $display("FAIL rstmid_done got %0d exp 0", done_cnt); else n_pass++;
    req_valid = '1;
    run_frame(0);
    req_valid = '0;
    rr_m = 1;
    n_chk++; if (obs_win !== 0) $display("FAIL rstmid_ptr got %0d exp 0", obs_win); else n_pass++;
    n_chk++; if (cap !== model_frame(0)) $display("FAIL rstmid_restart got %h exp %h", cap, model_frame(0)); else n_pass++;
  endtask

`ifdef PWM_CFG_LOOPBACK_CHECK_EN
  task automatic test_loopback();
    req_valid = 2'b01;
    run_frame(0);
    n_chk++; if (loopback_err !== 1'b0) $display("FAIL loop_clean got %b exp 0", loopback_err); else n_pass++;
    run_frame(3);
    inv_r = 1'b0;
    n_chk++; if (loopback_err !== 1'b1) $display("FAIL loop_err got %b exp 1", loopback_err); else n_pass++;
    run_frame(0);
    req_valid = '0;
    n_chk++; if (loopback_err !== 1'b0) $display("FAIL loop_clear got %b exp 0", loopback_err); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_timing();
    test_random();
    test_back_to_back();
    test_midframe_change();
    test_reset_midframe();
`ifdef PWM_CFG_LOOPBACK_CHECK_EN
    test_loopback();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
